// File: rtl/cdc_pkg.sv
// Shared constants for the 4-phase req/ack source controller.
// State encoding and synchroniser depth floor.
package cdc_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ_HI = 2'd1;
  localparam logic [1:0] ST_REQ_LO = 2'd2;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_chain_sr.sv
// Multi-flop synchroniser with synchronous active-high reset.
// Used for the asynchronous ack returning from the destination domain.
module sync_chain_sr #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack crossing: holds a word on
// data_out, sequences req, and aborts a stuck request on timeout.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int W              = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         req_out,
  output logic [W-1:0] data_out,
  input  logic         ack_async,
  output logic         busy,
  output logic         done,
  output logic         timeout_err,
  output logic         err_sticky,
  input  logic         err_clr
);

  localparam int NS = (SYNC_STAGES < SYNC_STAGES_MIN) ?
                      SYNC_STAGES_MIN : SYNC_STAGES;
  localparam int CW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]    state, state_nx;
  logic          ack_s;
  logic [W-1:0]  data_q;
  logic [CW-1:0] cnt;
  logic          req_q, done_q, to_q, sticky_q;
  logic          timed_out;
  logic          accept, to_hit;

  sync_chain_sr #(
    .STAGES(NS)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (ack_async),
    .q  (ack_s)
  );

  // A lingering ack from the last transfer blocks new work
  assign in_ready = (state == ST_IDLE) & ~ack_s & ~rst;
  assign accept   = in_valid & in_ready;

  // Ack arriving on the final cycle beats the timeout
  assign to_hit = TO_EN && (state == ST_REQ_HI) &&
                  !ack_s && (cnt == TO_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_REQ_HI;
      ST_REQ_HI: if (ack_s || to_hit) state_nx = ST_REQ_LO;
      ST_REQ_LO: if (!ack_s) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_q     <= 1'b0;
      data_q    <= '0;
      cnt       <= '0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      sticky_q  <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state  <= state_nx;
      req_q  <= (state_nx == ST_REQ_HI);
      done_q <= (state == ST_REQ_LO) && (state_nx == ST_IDLE) &&
                !timed_out;
      to_q   <= to_hit;
      if (accept) data_q <= in_data;
      if (TO_EN && state == ST_REQ_HI && state_nx == ST_REQ_HI)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      if (to_hit)       sticky_q <= 1'b1;
      else if (err_clr) sticky_q <= 1'b0;
      if (accept)       timed_out <= 1'b0;
      else if (to_hit)  timed_out <= 1'b1;
    end
  end

  assign req_out     = req_q & ~rst;
  assign data_out    = rst ? '0 : data_q;
  assign busy        = (state != ST_IDLE) & ~rst;
  assign done        = done_q & ~rst;
  assign timeout_err = to_q & ~rst;
  assign err_sticky  = sticky_q & ~rst;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx: words queued at issue,
// compared against data_out on done or timeout_err.
module tb_cdc_handshake_tx;

  localparam int W  = 8;
  localparam int NS = 2;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         req_out;
  logic [W-1:0] data_out;
  logic         ack_async;
  logic         busy;
  logic         done;
  logic         timeout_err;
  logic         err_sticky;
  logic         err_clr;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];

  cdc_handshake_tx #(
    .W(W),
    .SYNC_STAGES(NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .req_out(req_out),
    .data_out(data_out),
    .ack_async(ack_async),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err),
    .err_sticky(err_sticky),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic sb_cmp(input string tag);
    logic [W-1:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(tag, 32'(data_out), 32'(e));
    end
  endtask

  task automatic wait_req_low(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (req_out && n < 40);
  endtask

  task automatic wait_done(output int n, output int to_seen);
    n = 0;
    to_seen = 0;
    do begin
      tick();
      n++;
      if (timeout_err) to_seen++;
    end while (!done && n < 40);
  endtask

  int n, tos, dn;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    ack_async = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req", 32'(req_out), 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 32'(in_ready), 1);
    check("idle_busy", 32'(busy), 0);

    // basic transfer plus backpressure
    in_valid = 1'b1; in_data = 8'hA5; sb.push_back(8'hA5);
    tick();
    check("t1_req", 32'(req_out), 1);
    check("t1_data", 32'(data_out), 32'hA5);
    check("t1_busy", 32'(busy), 1);
    in_data = 8'h3C; sb.push_back(8'h3C);
    repeat (2) tick();
    check("bp_hold", 32'(data_out), 32'hA5);
    check("bp_ready", 32'(in_ready), 0);
    ack_async = 1'b1;
    wait_req_low(n);
    check("t1_req_fall", 32'(n), 3);
    tick();
    ack_async = 1'b0;
    wait_done(n, tos);
    check("t1_done_lat", 32'(n), NS + 1);
    check("t1_ready_back", 32'(in_ready), 1);
    sb_cmp("t1_sb");
    tick();
    check("t1_done_once", 32'(done), 0);
    check("bp_accept", 32'(data_out), 32'h3C);
    check("bp_req", 32'(req_out), 1);
    in_valid = 1'b0;
    ack_async = 1'b1;
    wait_req_low(n);
    check("t2_req_fall", 32'(n), 3);
    ack_async = 1'b0;
    wait_done(n, tos);
    check("t2_done", 32'(done), 1);
    sb_cmp("t2_sb");

    // timeout with no ack at all
    tick();
    in_valid = 1'b1; in_data = 8'h5A; sb.push_back(8'h5A);
    tick();
    in_valid = 1'b0;
    check("to_req", 32'(req_out), 1);
    dn = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (done) dn++;
    end while (req_out && n < 40);
    check("to_len", 32'(n), TO);
    check("to_pulse", 32'(timeout_err), 1);
    check("to_sticky", 32'(err_sticky), 1);
    sb_cmp("to_sb");
    tick();
    if (done) dn++;
    check("to_pulse_once", 32'(timeout_err), 0);
    check("to_no_done", 32'(dn), 0);
    check("to_idle", 32'(busy), 0);
    check("to_sticky_hold", 32'(err_sticky), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_clr", 32'(err_sticky), 0);

    // stale ack holds off new work
    ack_async = 1'b1;
    repeat (3) tick();
    check("stale_ready", 32'(in_ready), 0);
    in_valid = 1'b1; in_data = 8'h77;
    repeat (2) tick();
    check("stale_ignored", 32'(busy), 0);
    in_valid = 1'b0;
    ack_async = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!in_ready && n < 20);
    check("stale_release", 32'(n), NS);

    // reset during REQ_HI
    in_valid = 1'b1; in_data = 8'hE1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mr_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    tick();
    check("mr_req", 32'(req_out), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_pulses", 32'({done, timeout_err}), 0);
    rst = 1'b0;
    tick();
    check("mr_pulses_after", 32'({done, timeout_err}), 0);
    check("mr_ready", 32'(in_ready), 1);

    // ack_s rises on the final timeout cycle
    in_valid = 1'b1; in_data = 8'hD2; sb.push_back(8'hD2);
    tick();
    in_valid = 1'b0;
    repeat (13) tick();
    ack_async = 1'b1;
    tos = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (timeout_err) tos++;
    end while (req_out && n < 40);
    check("col_req_fall", 32'(n), 3);
    ack_async = 1'b0;
    wait_done(n, dn);
    check("col_no_to", 32'(tos + dn), 0);
    check("col_sticky", 32'(err_sticky), 0);
    check("col_done", 32'(done), 1);
    sb_cmp("col_sb");
    check("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
- Source-side controller for a 4-phase req/ack clock-domain crossing.
- Accepts a data word on a valid/ready interface and holds it stable on data_out.
- Drives req_out to the destination domain and sequences the return-to-zero protocol.
- Synchronises the asynchronous ack_async internally through a reset-able flop chain; a timeout recovers from a missing or dead destination.

Parameters:
- W, 8: width of in_data / data_out.
- SYNC_STAGES, 2: flops in the ack synchroniser chain; minimum 2.
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ_HI before abort; 0 disables the timeout.

Ports:
- clk  in  1  source-domain clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_data  in  W  upstream word
- in_ready  out  1  block can accept a word this cycle
- req_out  out  1  registered request to the destination domain
- data_out  out  W  registered data, stable while busy is 1
- ack_async  in  1  acknowledge from the destination domain, asynchronous
- busy  out  1  transfer in progress (state != IDLE)
- done  out  1  one-cycle pulse on successful completion
- timeout_err  out  1  one-cycle pulse on abort
- err_sticky  out  1  latched abort flag
- err_clr  in  1  clears err_sticky

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset: all outputs are 0 while rst is high, including in_ready. State goes to IDLE, the sync chain clears, and the timeout counter clears.
- ack_s: ack_async delayed by SYNC_STAGES flops.
- in_ready = (state == IDLE) & ~ack_s & ~rst. New transfers are refused until the previous ack has returned low.
- IDLE:
  - On in_valid & in_ready: capture in_data into data_out and go to REQ_HI.
  - req_out rises on the next clk edge, one cycle after acceptance.
- REQ_HI:
  - req_out = 1 and the timeout counter increments every cycle.
  - ack_s = 1: go to REQ_LO; req_out drops the following cycle.
  - Counter reaches TIMEOUT_CYCLES (when nonzero): go to REQ_LO, pulse timeout_err, set err_sticky. If ack_s = 1 in the same cycle, ack wins and there is no error.
- REQ_LO:
  - req_out = 0.
  - ack_s = 0: go to IDLE and pulse done. done is suppressed if this transfer timed out.
  - REQ_LO has no timeout.
- data_out: changes only on acceptance and otherwise holds its value, including after returning to IDLE.
- err_sticky: cleared by err_clr. If err_clr and a new timeout occur in the same cycle, set wins.
- Reset mid-transfer: on the next edge req_out = 0 and state = IDLE. No done or timeout_err pulse is produced.
- Worst-case successful round trip: 1 + 2×SYNC_STAGES cycles plus destination latency, plus 1 cycle to return to IDLE.

Decomposition:
- Shared package cdc_pkg:
  - state encoding constants ST_IDLE = 2'd0, ST_REQ_HI = 2'd1, ST_REQ_LO = 2'd2.
  - SYNC_STAGES_MIN = 2.
- Sub-module sync_chain_sr: a SYNC_STAGES-deep synchroniser with synchronous active-high reset.
  - The team's existing synchroniser uses an asynchronous reset, so this block does not reuse it.
- Top block: FSM, data register, timeout counter and flag logic.

Test Plan:
- Basic transfer, ack returned 3 cycles after req:
  - Stimulus: in_data = 0xA5, in_valid pulsed at cycle 0.
  - Cycle 1: req_out = 1, data_out = 0xA5, busy = 1.
  - req_out falls 2+1 cycles after ack rises.
  - After ack falls, done pulses exactly once (SYNC_STAGES+1 cycles later) and in_ready returns to 1.
- Backpressure:
  - Stimulus: in_valid held with in_data = 0x3C throughout transfer 1.
  - Not accepted while busy; data_out stays 0xA5.
  - Accepted on the first IDLE cycle; data_out then becomes 0x3C.
- Timeout, TIMEOUT_CYCLES = 16, ack never asserted:
  - req_out drops after 16 cycles in REQ_HI.
  - timeout_err pulses once and err_sticky = 1; no done.
  - err_clr clears err_sticky the next cycle.
- Stale ack:
  - Stimulus: ack_async held high while IDLE.
  - in_ready = 0 and in_valid is ignored.
  - When ack drops, in_ready = 1 after SYNC_STAGES cycles.
- Reset mid-transfer:
  - Stimulus: rst asserted for one cycle during REQ_HI.
  - Next edge: req_out = 0, busy = 0, no pulses.
  - After release: in_ready = 1 once ack_s = 0.
- Ack/timeout collision:
  - Stimulus: ack_s rises in the cycle the counter reaches 16.
  - No timeout_err, normal completion, done pulses.
